axil_mem_responder: RTL and testbench

AXI4-Lite subordinate that terminates the bridge's AXI manager port (the `o_awm*`/`o_wm*`/`o_bm*`/`o_arm*`/`o_rm*` side) with a byte-addressable word memory. Write address and write data are accepted independently, and a single write response is returned per write. Reads are served with one-cycle registered latency. Out-of-range addresses return SLVERR without corrupting memory. It is the AXI-side endpoint used to exercise and deploy the Wishbone-to-AXI direction of the bridge.

---
 rtl/axil_pkg.sv | 7 +
 rtl/axil_mem_responder_if.sv | 23 ++
 rtl/axil_mem_array.sv | 29 ++
 rtl/axil_mem_responder.sv | 98 +++++++++
 tb/tb_axil_mem_responder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// axil_pkg: response codes and FSM encodings shared by the AXI4-Lite memory responder.
package axil_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axil_mem_responder_if.sv
// axil_mem_responder_if: AXI4-Lite bus between a manager and the memory responder.
interface axil_mem_responder_if #(parameter int AW = 12);
    logic [AW-1:0] awaddr;
    logic          awvalid, awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [AW-1:0] araddr;
    logic          arvalid, arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;
    modport master(
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
    modport slave(
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axil_mem_array.sv
// axil_mem_array: DEPTH x 32 word memory, byte-enabled sync write, sync read-before-write.
module axil_mem_array #(
    parameter int DEPTH = 256,
    parameter int MW    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          we,
    input  logic [MW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          re,
    input  logic          rclr,
    input  logic [MW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++)
            if (we && wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end

    // rclr zeroes the read register for out-of-range reads
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rdata <= '0;
        else if (re) rdata <= rclr ? '0 : mem[raddr];
    end
endmodule

// File: rtl/axil_mem_responder.sv
// axil_mem_responder: AXI4-Lite subordinate backed by a word memory; independent
// write and read FSMs, registered outputs, SLVERR for out-of-range word indices.
module axil_mem_responder
    import axil_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DEPTH = 256
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    axil_mem_responder_if.slave  bus
);
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-2:0] LIMIT = (AW-1)'(DEPTH);

    w_state_t      w_q, w_d;
    r_state_t      r_q, r_d;
    logic [AW-3:0] aw_q;
    logic [31:0]   wd_q;
    logic [3:0]    ws_q;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic          have_aw, have_w, commit, c_oor, ar_oor;
    logic [AW-3:0] c_idx;
    logic [31:0]   c_data;
    logic [3:0]    c_strb;
    logic          unused;

    assign unused  = ^{bus.awaddr[1:0], bus.araddr[1:0]};
    assign aw_hs   = bus.awvalid & bus.awready;
    assign w_hs    = bus.wvalid & bus.wready;
    assign b_hs    = bus.bvalid & bus.bready;
    assign ar_hs   = bus.arvalid & bus.arready;
    assign r_hs    = bus.rvalid & bus.rready;
    assign have_aw = w_q == W_HAVE_AW;
    assign have_w  = w_q == W_HAVE_W;
    // a write commits on the edge where the later of its two halves arrives
    assign commit  = (aw_hs | have_aw) & (w_hs | have_w);
    assign c_idx   = have_aw ? aw_q : bus.awaddr[AW-1:2];
    assign c_data  = have_w ? wd_q : bus.wdata;
    assign c_strb  = have_w ? ws_q : bus.wstrb;
    assign c_oor   = {1'b0, c_idx} >= LIMIT;
    assign ar_oor  = {1'b0, bus.araddr[AW-1:2]} >= LIMIT;
    assign bus.rlast = 1'b1;

    always_comb begin
        w_d = commit                      ? W_RESP    :
              (w_q == W_RESP && b_hs)     ? W_IDLE    :
              (w_q == W_IDLE && aw_hs)    ? W_HAVE_AW :
              (w_q == W_IDLE && w_hs)     ? W_HAVE_W  : w_q;
        r_d = ar_hs ? R_DATA : r_hs ? R_IDLE : r_q;
    end

    // handshake outputs are registered copies of the next-state decode
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_q         <= W_IDLE;
            r_q         <= R_IDLE;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= RESP_OKAY;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rresp   <= RESP_OKAY;
            aw_q        <= '0;
            wd_q        <= '0;
            ws_q        <= '0;
        end else begin
            w_q         <= w_d;
            r_q         <= r_d;
            bus.awready <= w_d == W_IDLE || w_d == W_HAVE_W;
            bus.wready  <= w_d == W_IDLE || w_d == W_HAVE_AW;
            bus.bvalid  <= w_d == W_RESP;
            bus.arready <= r_d == R_IDLE;
            bus.rvalid  <= r_d == R_DATA;
            if (commit) bus.bresp <= c_oor ? RESP_SLVERR : RESP_OKAY;
            if (ar_hs) bus.rresp <= ar_oor ? RESP_SLVERR : RESP_OKAY;
            if (aw_hs) aw_q <= bus.awaddr[AW-1:2];
            if (w_hs) begin
                wd_q <= bus.wdata;
                ws_q <= bus.wstrb;
            end
        end
    end

    axil_mem_array #(.DEPTH(DEPTH), .MW(MW)) u_mem (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .we     (commit & ~c_oor),
        .waddr  (c_idx[MW-1:0]),
        .wdata  (c_data),
        .wstrb  (c_strb),
        .re     (ar_hs),
        .rclr   (ar_oor),
        .raddr  (bus.araddr[MW+1:2]),
        .rdata  (bus.rdata)
    );
endmodule

// File: tb/tb_axil_mem_responder.sv
// tb_axil_mem_responder: directed stimulus with B/R scoreboard queues checked by a monitor.
module tb_axil_mem_responder;
    logic clk = 0;
    logic rst_n = 0;
    int checks = 0;
    int failures = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    axil_mem_responder_if #(.AW(12)) bus ();
    axil_mem_responder #(.AW(12), .DEPTH(256)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.bvalid && bus.bready) begin
            chk("b_pending", 64'(bq.size() != 0), 1);
            if (bq.size() != 0) chk("bresp", bus.bresp, bq.pop_front());
        end
        if (rst_n && bus.rvalid && bus.rready) begin
            chk("r_pending", 64'(rq.size() != 0), 1);
            if (rq.size() != 0) chk("rresp_rdata_rlast", {bus.rlast, bus.rresp, bus.rdata}, {1'b1, rq.pop_front()});
        end
    end

    task automatic send_aw(input logic [11:0] a);
        int n = 0;
        bus.awaddr = a; bus.awvalid = 1;
        while (!bus.awready && n < 20) begin @(negedge clk); n++; end
        chk("aw_accept", bus.awready, 1);
        @(negedge clk);
        bus.awvalid = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1;
        while (!bus.wready && n < 20) begin @(negedge clk); n++; end
        chk("w_accept", bus.wready, 1);
        @(negedge clk);
        bus.wvalid = 0;
    endtask

    task automatic send_ar(input logic [11:0] a, input logic [31:0] d, input logic [1:0] r);
        int n = 0;
        rq.push_back({r, d});
        bus.araddr = a; bus.arvalid = 1;
        while (!bus.arready && n < 20) begin @(negedge clk); n++; end
        chk("ar_accept", bus.arready, 1);
        @(negedge clk);
        bus.arvalid = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
        bq.push_back(r);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic drain();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin @(negedge clk); n++; end
        chk("drain_empty", 64'(bq.size() + rq.size()), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen_b;
        bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
        bus.bready = 1; bus.araddr = 0; bus.arvalid = 0; bus.rready = 1;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata, bus.rlast},
            {8'b0, 2'b0, 32'h0, 1'b1});
        rst_n = 1;
        @(negedge clk);
        chk("readies_after_reset", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // basic write then read
        wr(12'h010, 32'hDEADBEEF, 4'hF, 2'b00);
        chk("b_latency", bus.bvalid, 1);
        drain();
        send_ar(12'h010, 32'hDEADBEEF, 2'b00);
        chk("r_latency", bus.rvalid, 1);
        drain();

        // W first, AW three cycles later
        bq.push_back(2'b00);
        send_w(32'h12345678, 4'hF);
        chk("w_first_readies", {bus.awready, bus.wready}, 2'b10);
        repeat (2) @(negedge clk);
        send_aw(12'h030);
        drain();
        send_ar(12'h030, 32'h12345678, 2'b00);
        drain();

        // AW first, W three cycles later
        bq.push_back(2'b00);
        send_aw(12'h034);
        chk("aw_first_readies", {bus.awready, bus.wready}, 2'b01);
        repeat (2) @(negedge clk);
        send_w(32'h9ABCDEF0, 4'hF);
        drain();
        send_ar(12'h034, 32'h9ABCDEF0, 2'b00);
        drain();

        // byte strobes
        wr(12'h040, 32'h11223344, 4'hF, 2'b00);
        wr(12'h040, 32'hAABBCCDD, 4'b0101, 2'b00);
        drain();
        send_ar(12'h040, 32'h11BB33DD, 2'b00);
        wr(12'h040, 32'hFFFFFFFF, 4'b0000, 2'b00);
        drain();
        send_ar(12'h040, 32'h11BB33DD, 2'b00);
        drain();

        // out of range, must not alias onto word 0
        wr(12'h000, 32'hCAFEF00D, 4'hF, 2'b00);
        wr(12'h400, 32'h0BADBAD0, 4'hF, 2'b10);
        drain();
        send_ar(12'h000, 32'hCAFEF00D, 2'b00);
        send_ar(12'h400, 32'h00000000, 2'b10);
        drain();

        // B backpressure
        bus.bready = 0;
        wr(12'h050, 32'h00000055, 4'hF, 2'b00);
        for (int i = 0; i < 5; i++) begin
            chk("b_stall", {bus.bvalid, bus.bresp, bus.awready, bus.wready}, 5'b1_00_00);
            @(negedge clk);
        end
        bus.bready = 1;
        drain();

        // R backpressure
        bus.rready = 0;
        send_ar(12'h050, 32'h00000055, 2'b00);
        for (int i = 0; i < 5; i++) begin
            chk("r_stall", {bus.rvalid, bus.arready, bus.rresp, bus.rdata}, {1'b1, 1'b0, 2'b00, 32'h55});
            @(negedge clk);
        end
        bus.rready = 1;
        drain();

        // same-edge read and write to one word returns old data
        wr(12'h020, 32'h1, 4'hF, 2'b00);
        drain();
        fork
            wr(12'h020, 32'h2, 4'hF, 2'b00);
            send_ar(12'h020, 32'h1, 2'b00);
        join
        drain();
        send_ar(12'h020, 32'h2, 2'b00);
        drain();

        // reset mid-transaction drops the latched AW
        send_aw(12'h060);
        rst_n = 0;
        #1;
        chk("mid_reset_outputs",
            {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata, bus.rlast},
            {8'b0, 2'b0, 32'h0, 1'b1});
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        send_w(32'h77777777, 4'hF);
        seen_b = 0;
        for (int i = 0; i < 8; i++) begin
            seen_b |= bus.bvalid;
            @(negedge clk);
        end
        chk("no_b_after_reset", seen_b, 0);
        chk("w_held_after_reset", {bus.awready, bus.wready}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
